alu_pipe: RTL

//  Parametrised, handshaked successor to the processor's 16-bit combinational ALU, sitting in the EX stage.

---
 rtl/alu_pipe_pkg.sv | 38 +++
 rtl/alu_seq_mul.sv | 64 ++++++
 rtl/alu_pipe.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_pkg.sv
// Shared definitions for the pipelined EX-stage ALU: operation codes,
// FSM state encoding and the helper that spots multiply operations.
package alu_pipe_pkg;

  localparam int OP_W = 4;

  // 4-bit operation codes presented on alu_pipe.op
  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_MOV  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_NAND = 4'h6,
    OP_NOR  = 4'h7,
    OP_XNOR = 4'h8,
    OP_NOT  = 4'h9,
    OP_SHL  = 4'hA,
    OP_SHR  = 4'hB,
    OP_SRA  = 4'hC,
    OP_MUL  = 4'hD,
    OP_MULH = 4'hE,
    OP_RSVD = 4'hF
  } op_e;

  // Top-level control FSM: IDLE accepts work, MUL waits for the multiplier
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  // True for the two operations handled by the iterative multiplier
  function automatic logic is_mul(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH);
  endfunction

endpackage

// File: rtl/alu_seq_mul.sv
// Iterative HW x HW unsigned multiplier, radix-2 shift-add, one multiplier
// bit per cycle. A start pulse loads the operands; the unit then stays busy
// for exactly HW cycles. done is high during the final iteration cycle, and
// product carries the complete result in that same cycle so the caller can
// register it on the closing edge. rst or flush discards any partial product.
module alu_seq_mul #(
  parameter int HW = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            start,
  input  logic [HW-1:0]   a,
  input  logic [HW-1:0]   b,
  output logic            busy,
  output logic            done,
  output logic [2*HW-1:0] product
);

  localparam int CNT_W = (HW > 1) ? $clog2(HW) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(HW - 1);

  logic [CNT_W-1:0]  count;
  logic [2*HW-1:0]   acc;
  logic [2*HW-1:0]   mcand;
  logic [HW-1:0]     mplier;
  logic [2*HW-1:0]   acc_next;

  // Partial sum including the current multiplier bit
  always_comb begin
    acc_next = acc + (mplier[0] ? mcand : '0);
  end

  assign done    = busy && (count == LAST);
  assign product = acc_next;

  // Iteration engine: load on start, then shift-add one bit per cycle
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
    end else if (start && !busy) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= '0;
      mcand  <= {{HW{1'b0}}, a};
      mplier <= b;
    end else if (busy) begin
      acc    <= acc_next;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      if (count == LAST) begin
        busy  <= 1'b0;
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined, handshaked EX-stage ALU. Single-cycle registered add/sub/move/
// logic/shift; half-width multiplies run on alu_seq_mul over WIDTH/2 cycles.
// A tag rides along with each operation to the result port.
// Optional build macro: ALU_PIPE_FLAGS_EN adds registered zf/nf/vf outputs.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both high. A source holding valid without ready keeps its payload stable;
// ready never depends on the same-side valid. in_ready = IDLE and the output
// register either empty or being drained this cycle; while out_valid is high
// and out_ready low, y/cout/res_tag (and flags) hold.
module alu_pipe
  import alu_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int TAG_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [TAG_W-1:0] op_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output state_e           dbg_state,
  output logic [TAG_W-1:0] res_tag
`ifdef ALU_PIPE_FLAGS_EN
  ,
  output logic             zf,
  output logic             nf,
  output logic             vf
`endif
);

  localparam int HW   = WIDTH / 2;
  localparam int SH_W = $clog2(WIDTH);

  state_e           state;
  op_e              op_q;
  logic             accept;
  logic [TAG_W-1:0] pend_tag;

  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   diff;
  logic [SH_W-1:0]  sh_amt;
  logic             sh_big;
  logic [WIDTH-1:0] sra_res;
  logic [WIDTH-1:0] alu_y;
  logic             alu_c;

  logic             mul_start;
  logic             mul_busy;
  logic             mul_done;
  logic [HW-1:0]    mul_a;
  logic [HW-1:0]    mul_b;
  logic [WIDTH-1:0] mul_product;

  assign op_q      = op_e'(op);
  assign in_ready  = (state == ST_IDLE) && !mul_busy && (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign mul_start = accept && is_mul(op_q);
  assign dbg_state = state;

  // MULH multiplies the upper halves, MUL the lower halves
  assign mul_a = (op_q == OP_MULH) ? a[WIDTH-1:HW] : a[HW-1:0];
  assign mul_b = (op_q == OP_MULH) ? b[WIDTH-1:HW] : b[HW-1:0];

  alu_seq_mul #(
    .HW(HW)
  ) u_mul (
    .clk     (clk),
    .rst     (rst),
    .flush   (flush),
    .start   (mul_start),
    .a       (mul_a),
    .b       (mul_b),
    .busy    (mul_busy),
    .done    (mul_done),
    .product (mul_product)
  );

  // Adder/subtractor with carry out; SUB carry is the no-borrow (a >= b) flag
  always_comb begin
    sum  = {1'b0, a} + {1'b0, b};
    diff = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, 1'b1};
  end

  // Shift amount uses the low bits of b; any higher bit saturates the shift
  always_comb begin
    sh_amt  = b[SH_W-1:0];
    sh_big  = |b[WIDTH-1:SH_W];
    sra_res = $signed(a) >>> sh_amt;
  end

  // Single-cycle result mux for every non-multiply operation
  always_comb begin
    alu_y = '0;
    alu_c = 1'b0;
    case (op_q)
      OP_ADD: begin
        alu_y = sum[WIDTH-1:0];
        alu_c = sum[WIDTH];
      end
      OP_SUB: begin
        alu_y = diff[WIDTH-1:0];
        alu_c = diff[WIDTH];
      end
      OP_MOV:  alu_y = a;
      OP_AND:  alu_y = a & b;
      OP_OR:   alu_y = a | b;
      OP_XOR:  alu_y = a ^ b;
      OP_NAND: alu_y = ~(a & b);
      OP_NOR:  alu_y = ~(a | b);
      OP_XNOR: alu_y = ~(a ^ b);
      OP_NOT:  alu_y = ~a;
      OP_SHL:  alu_y = sh_big ? '0 : (a << sh_amt);
      OP_SHR:  alu_y = sh_big ? '0 : (a >> sh_amt);
      OP_SRA:  alu_y = sh_big ? {WIDTH{a[WIDTH-1]}} : sra_res;
      default: alu_y = '0;
    endcase
  end

`ifdef ALU_PIPE_FLAGS_EN
  logic alu_v;

  // Signed overflow: operands agree in sign (after negating b for SUB) but result differs
  always_comb begin
    alu_v = 1'b0;
    case (op_q)
      OP_ADD: alu_v = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      OP_SUB: alu_v = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      default: alu_v = 1'b0;
    endcase
  end
`endif

  // Control FSM and output register; rst/flush clear everything first
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= ST_IDLE;
      out_valid <= 1'b0;
      y         <= '0;
      cout      <= 1'b0;
      res_tag   <= '0;
      pend_tag  <= '0;
`ifdef ALU_PIPE_FLAGS_EN
      zf        <= 1'b0;
      nf        <= 1'b0;
      vf        <= 1'b0;
`endif
    end else begin
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_mul(op_q)) begin
              state    <= ST_MUL;
              pend_tag <= op_tag;
            end else begin
              out_valid <= 1'b1;
              y         <= alu_y;
              cout      <= alu_c;
              res_tag   <= op_tag;
`ifdef ALU_PIPE_FLAGS_EN
              zf        <= (alu_y == '0);
              nf        <= alu_y[WIDTH-1];
              vf        <= alu_v;
`endif
            end
          end
        end
        ST_MUL: begin
          if (mul_done) begin
            state     <= ST_IDLE;
            out_valid <= 1'b1;
            y         <= mul_product;
            cout      <= 1'b0;
            res_tag   <= pend_tag;
`ifdef ALU_PIPE_FLAGS_EN
            zf        <= (mul_product == '0);
            nf        <= mul_product[WIDTH-1];
            vf        <= 1'b0;
`endif
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
